// File: rtl/serial_frame_deserializer_if.sv
// Bundle between the header detector's serial pass-through and the deserializer.
// master drives enable, serial bit and payload-valid; slave reports assembled words.
// Pure wiring, no storage; parameters must match the deserializer instance.
interface serial_frame_deserializer_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
);
  logic             clkEN;
  logic             ser_in;
  logic             ser_valid;
  logic [WIDTH-1:0] word_out;
  logic             word_valid;
  logic             partial;
  logic             frame_done;
  logic [CNT_W-1:0] frame_words;

  modport master (
    output clkEN, ser_in, ser_valid,
    input  word_out, word_valid, partial, frame_done, frame_words
  );

  modport slave (
    input  clkEN, ser_in, ser_valid,
    output word_out, word_valid, partial, frame_done, frame_words
  );
endinterface

// File: rtl/serial_frame_deserializer.sv
// Packs clkEN-qualified payload bits into WIDTH-bit words, flushing a short word at frame end.
// Latency: word_valid / frame_done 1 clk after the capturing clkEN edge.
// No backpressure: every word is emitted as a 1-clk pulse; DESER_LSB_FIRST_EN selects LSB-first packing.
module serial_frame_deserializer #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  serial_frame_deserializer_if.slave   bus
);

  localparam int BCW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] sr_nxt;
  logic [WIDTH-1:0] sr_shift;
  logic [WIDTH-1:0] flush_word;
  logic [WIDTH-1:0] word_q;
  logic [WIDTH-1:0] word_nxt;
  logic [BCW-1:0]   bit_cnt;
  logic [BCW-1:0]   bit_cnt_nxt;
  logic [CNT_W-1:0] fw_q;
  logic [CNT_W-1:0] fw_nxt;
  logic [CNT_W-1:0] fw_inc;
  logic             wv_q;
  logic             wv_nxt;
  logic             part_q;
  logic             part_nxt;
  logic             bit_sample;
  logic             end_sample;
  logic             word_full;

  // Only clkEN edges advance the datapath; a low ser_valid on such an edge ends the frame.
  assign bit_sample = bus.clkEN & bus.ser_valid;
  assign end_sample = bus.clkEN & ~bus.ser_valid;

  // The incoming bit completes a word when WIDTH-1 bits are already held.
  assign word_full  = (bit_cnt == BCW'(WIDTH - 1));

  // Word count sticks at all-ones once saturated.
  assign fw_inc     = (&fw_q) ? fw_q : fw_q + 1'b1;

`ifdef DESER_LSB_FIRST_EN
  // Right shift: the newest bit enters at the top, so the first bit settles in bit 0.
  assign sr_shift = {bus.ser_in, sr[WIDTH-1:1]};

  // Collected bits sit in the top bit_cnt positions; drop everything below them.
  logic [BCW:0] flush_rsh;
  assign flush_rsh  = (BCW+1)'(WIDTH) - {1'b0, bit_cnt};
  assign flush_word = sr >> flush_rsh;
`else
  // Left shift: the newest bit enters at bit 0, so the first bit settles in the MSB.
  assign sr_shift = {sr[WIDTH-2:0], bus.ser_in};

  // Collected bits are already right-justified; mask off stale bits from the previous word.
  assign flush_word = sr & ~({WIDTH{1'b1}} << bit_cnt);
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and datapath next values; pulses default low so they last one clk.
  always_comb begin
    state_nxt   = state;
    sr_nxt      = sr;
    bit_cnt_nxt = bit_cnt;
    word_nxt    = word_q;
    fw_nxt      = fw_q;
    wv_nxt      = 1'b0;
    part_nxt    = 1'b0;

    case (state)
      IDLE: begin
        if (bit_sample) begin
          sr_nxt      = sr_shift;
          bit_cnt_nxt = BCW'(1);
          fw_nxt      = '0;
          state_nxt   = COLLECT;
        end
      end

      COLLECT: begin
        if (bit_sample) begin
          sr_nxt = sr_shift;
          if (word_full) begin
            word_nxt    = sr_shift;
            wv_nxt      = 1'b1;
            bit_cnt_nxt = '0;
            fw_nxt      = fw_inc;
          end else begin
            bit_cnt_nxt = bit_cnt + 1'b1;
          end
        end else if (end_sample) begin
          state_nxt = DONE;
          if (bit_cnt != '0) begin
            word_nxt = flush_word;
            wv_nxt   = 1'b1;
            part_nxt = 1'b1;
            fw_nxt   = fw_inc;
          end
        end
      end

      DONE: begin
        // Leaves after one clk regardless of clkEN; any ser_valid seen here is dropped.
        sr_nxt      = '0;
        bit_cnt_nxt = '0;
        state_nxt   = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr      <= '0;
      bit_cnt <= '0;
      word_q  <= '0;
      fw_q    <= '0;
      wv_q    <= 1'b0;
      part_q  <= 1'b0;
    end else begin
      sr      <= sr_nxt;
      bit_cnt <= bit_cnt_nxt;
      word_q  <= word_nxt;
      fw_q    <= fw_nxt;
      wv_q    <= wv_nxt;
      part_q  <= part_nxt;
    end
  end

  assign bus.word_out    = word_q;
  assign bus.word_valid  = wv_q;
  assign bus.partial     = part_q;
  assign bus.frame_done  = (state == DONE);
  assign bus.frame_words = fw_q;

endmodule
